// File: rtl/smpl_pkg.sv
// Shared types and defaults for the sample acquisition front-end.
package smpl_pkg;

    localparam int DN_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEEK,
        ST_CAPTURE
    } trig_state_t;

endpackage

// File: rtl/smpl_decim.sv
// Keeps one valid ADC sample out of every decim+1; restart realigns the phase.
module smpl_decim
    import smpl_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clkSmpl,
    input  logic             n_reset,
    input  logic             adc_valid,
    input  logic             restart,
    input  logic [DIV_W-1:0] decim,
    output logic             take
);

    logic [DIV_W-1:0] dcnt;

    assign take = adc_valid && (dcnt == decim);

    always_ff @(posedge clkSmpl or negedge n_reset) begin
        if (!n_reset) begin
            dcnt <= '0;
        end else if (restart) begin
            dcnt <= '0;
        end else if (adc_valid) begin
            dcnt <= (dcnt == decim) ? '0 : dcnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/smpl_trigger.sv
// Decimating edge trigger with hysteresis and auto-timeout; emits NS samples
// per armed capture towards the display sample FIFO.
module smpl_trigger
    import smpl_pkg::*;
#(
    parameter int DN    = DN_DEFAULT,
    parameter int NS    = 320,
    parameter int DIV_W = 16,
    parameter int HYST  = 8,
    parameter int TO_W  = 20
) (
    input  logic             clkSmpl,
    input  logic             n_reset,
    input  logic [DN-1:0]    adc_data,
    input  logic             adc_valid,
    input  logic             arm,
    input  logic [DN-1:0]    trig_level,
    input  logic             trig_slope,
    input  logic             trig_auto,
    input  logic [DIV_W-1:0] decim,
    input  logic [TO_W-1:0]  timeout,
    output logic [DN-1:0]    smpl_data,
    output logic             smpl_en,
    output logic             triggered,
    output logic             forced,
    output logic             busy
);

    localparam int            NW       = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [NW-1:0] LAST_IDX = NW'(NS - 1);
    localparam logic [DN:0]   HYST_EXT = (DN + 1)'(HYST);

    trig_state_t   state, state_next;
    logic          arm_s1, arm_s2, arm_s3, arm_edge;
    logic          take, restart, fire, fire_forced, emit;
    logic          hyst_flag, last_q;
    logic [TO_W-1:0] tocnt;
    logic [TO_W:0]   to_next;
    logic [NW-1:0]   ncnt;
    logic [DN:0]     lo_ext, hi_ext;
    logic [DN-1:0]   lo_thr, hi_thr;
    logic            flag_set, real_trig, auto_trig;

    smpl_decim #(
        .DIV_W(DIV_W)
    ) u_decim (
        .clkSmpl  (clkSmpl),
        .n_reset  (n_reset),
        .adc_valid(adc_valid),
        .restart  (restart),
        .decim    (decim),
        .take     (take)
    );

    always_ff @(posedge clkSmpl or negedge n_reset) begin
        if (!n_reset) begin
            arm_s1 <= 1'b0;
            arm_s2 <= 1'b0;
            arm_s3 <= 1'b0;
        end else begin
            arm_s1 <= arm;
            arm_s2 <= arm_s1;
            arm_s3 <= arm_s2;
        end
    end

    assign arm_edge = arm_s2 & ~arm_s3;

    // Hysteresis thresholds are computed one bit wider so they can saturate.
    always_comb begin
        lo_ext    = {1'b0, trig_level} - HYST_EXT;
        hi_ext    = {1'b0, trig_level} + HYST_EXT;
        lo_thr    = lo_ext[DN] ? '0 : lo_ext[DN-1:0];
        hi_thr    = hi_ext[DN] ? '1 : hi_ext[DN-1:0];
        flag_set  = trig_slope ? (adc_data > hi_thr) : (adc_data < lo_thr);
        real_trig = hyst_flag &&
                    (trig_slope ? (adc_data <= trig_level) : (adc_data >= trig_level));
        to_next   = {1'b0, tocnt} + (TO_W + 1)'(1);
        auto_trig = trig_auto && (timeout != '0) && (to_next == {1'b0, timeout});
    end

    always_ff @(posedge clkSmpl or negedge n_reset) begin
        if (!n_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The sample that completes the timeout count is itself the forced trigger.
    always_comb begin
        state_next  = state;
        restart     = 1'b0;
        fire        = 1'b0;
        fire_forced = 1'b0;
        emit        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm_edge) begin
                    state_next = ST_SEEK;
                    restart    = 1'b1;
                end
            end
            ST_SEEK: begin
                if (take && (real_trig || auto_trig)) begin
                    fire        = 1'b1;
                    fire_forced = !real_trig;
                    emit        = 1'b1;
                    state_next  = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (last_q) begin
                    state_next = ST_IDLE;
                end else if (take) begin
                    emit = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // last_q holds Capture for the cycle in which the final sample is on the bus.
    always_ff @(posedge clkSmpl or negedge n_reset) begin
        if (!n_reset) begin
            smpl_data <= '0;
            smpl_en   <= 1'b0;
            hyst_flag <= 1'b0;
            tocnt     <= '0;
            ncnt      <= '0;
            last_q    <= 1'b0;
            forced    <= 1'b0;
        end else begin
            if (take) begin
                smpl_data <= adc_data;
            end
            smpl_en <= emit;
            if (restart) begin
                hyst_flag <= 1'b0;
                tocnt     <= '0;
            end else if (state == ST_SEEK && take) begin
                if (flag_set) begin
                    hyst_flag <= 1'b1;
                end
                if (tocnt != '1) begin
                    tocnt <= tocnt + TO_W'(1);
                end
            end
            if (fire) begin
                forced <= fire_forced;
                ncnt   <= NW'(1);
                last_q <= 1'b0;
            end else if (state == ST_CAPTURE) begin
                if (last_q) begin
                    last_q <= 1'b0;
                end else if (emit) begin
                    if (ncnt == LAST_IDX) begin
                        last_q <= 1'b1;
                    end else begin
                        ncnt <= ncnt + NW'(1);
                    end
                end
            end
        end
    end

    assign triggered = (state == ST_CAPTURE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_smpl_trigger.sv
// Directed bench for smpl_trigger: table vectors plus multi-cycle capture runs.
module tb_smpl_trigger;

    localparam int M_CONST = 0;
    localparam int M_RAMP  = 1;
    localparam int M_TRI   = 2;

    typedef struct packed {
        logic [9:0] adc;
        logic       valid;
        logic       exp_en;
        logic [9:0] exp_data;
    } vec_t;

    logic        clkSmpl;
    logic        n_reset;
    logic [9:0]  adc_data;
    logic        adc_valid;
    logic        arm;
    logic [9:0]  trig_level;
    logic        trig_slope;
    logic        trig_auto;
    logic [15:0] decim;
    logic [19:0] timeout;
    logic [9:0]  smpl_data;
    logic        smpl_en;
    logic        triggered;
    logic        forced;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          mode, base, t;
    logic [9:0]  drv_cur, drv_prev;
    vec_t        tbl [14];
    int          tbl_en;
    int          cap_n, cap_fc;
    logic [9:0]  cap_v0, cap_vp;
    logic        cap_f0;

    smpl_trigger #(
        .DN(10), .NS(320), .DIV_W(16), .HYST(8), .TO_W(20)
    ) dut (
        .clkSmpl   (clkSmpl),
        .n_reset   (n_reset),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .arm       (arm),
        .trig_level(trig_level),
        .trig_slope(trig_slope),
        .trig_auto (trig_auto),
        .decim     (decim),
        .timeout   (timeout),
        .smpl_data (smpl_data),
        .smpl_en   (smpl_en),
        .triggered (triggered),
        .forced    (forced),
        .busy      (busy)
    );

    initial clkSmpl = 1'b0;
    always #5 clkSmpl = ~clkSmpl;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clkSmpl);
        #1;
    endtask

    function automatic logic [9:0] genSample(input int m, input int b, input int tt);
        int p, v;
        case (m)
            M_RAMP:  v = b + tt;
            M_TRI: begin
                p = tt % 400;
                v = (p < 200) ? 100 + 4 * p : 900 - 4 * (p - 200);
            end
            default: v = b;
        endcase
        return v[9:0];
    endfunction

    task automatic driveSample(input logic [9:0] v, input logic valid);
        adc_data  = v;
        adc_valid = valid;
        if (valid) begin
            drv_prev = drv_cur;
            drv_cur  = v;
        end
    endtask

    task automatic applyStimulus();
        driveSample(genSample(mode, base, t), 1'b1);
        t++;
    endtask

    task automatic setCfg(input int lvl, input logic slp, input logic aut,
                          input int dec, input int tmo);
        trig_level = lvl[9:0];
        trig_slope = slp;
        trig_auto  = aut;
        decim      = dec[15:0];
        timeout    = tmo[19:0];
    endtask

    task automatic armPulse();
        logic seen;
        seen = 1'b0;
        arm  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) arm = 1'b0;
            applyStimulus();
            tick();
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        arm = 1'b0;
        checkOutput("arm_to_busy", seen, 1);
    endtask

    task automatic idleCheck(input int cycles);
        int any_en, any_busy;
        any_en   = 0;
        any_busy = 0;
        for (int i = 0; i < cycles; i++) begin
            applyStimulus();
            tick();
            if (smpl_en) any_en++;
            if (busy) any_busy++;
        end
        checkOutput("idle_no_en", any_en, 0);
        checkOutput("idle_not_busy", any_busy, 0);
    endtask

    task automatic seekHold(input int cycles);
        int bad_en, bad_trig, not_busy;
        bad_en   = 0;
        bad_trig = 0;
        not_busy = 0;
        for (int i = 0; i < cycles; i++) begin
            applyStimulus();
            tick();
            if (smpl_en) bad_en++;
            if (triggered) bad_trig++;
            if (!busy) not_busy++;
        end
        checkOutput("seek_no_en", bad_en, 0);
        checkOutput("seek_no_trig", bad_trig, 0);
        checkOutput("seek_busy", not_busy, 0);
    endtask

    // Runs until busy falls after the last sample (or stop_at samples seen).
    task automatic runCapture(input int budget, input int step_exp, input int gap_exp,
                              input int arm_at, input int stop_at,
                              output int n_en, output int first_c,
                              output logic [9:0] v0, output logic [9:0] v_prev,
                              output logic f0);
        int         last_c;
        logic [9:0] last_v, diff;
        logic       done;
        n_en    = 0;
        first_c = -1;
        last_c  = 0;
        last_v  = '0;
        v0      = '0;
        v_prev  = '0;
        f0      = 1'b0;
        done    = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            if (arm_at >= 0) arm = (n_en >= arm_at) && (n_en < arm_at + 6);
            applyStimulus();
            tick();
            if (smpl_en) begin
                checkOutput("cap_data", smpl_data, drv_cur);
                checkOutput("cap_triggered", triggered, 1);
                if (n_en == 0) begin
                    first_c = c;
                    v0      = smpl_data;
                    v_prev  = drv_prev;
                    f0      = forced;
                end else begin
                    if (gap_exp > 0) checkOutput("cap_gap", c - last_c, gap_exp);
                    diff = smpl_data - last_v;
                    if (step_exp >= 0) checkOutput("cap_step", diff, step_exp);
                end
                last_c = c;
                last_v = smpl_data;
                n_en++;
                if (n_en == stop_at) done = 1'b1;
            end else if (n_en > 0 && !busy) begin
                checkOutput("busy_fall_latency", c - last_c, 1);
                checkOutput("triggered_fall", triggered, 0);
                done = 1'b1;
            end
        end
        if (!done) checkOutput("cap_timeout", 0, 1);
        arm = 1'b0;
    endtask

    initial begin
        n_reset  = 1'b1;
        arm      = 1'b0;
        mode     = M_CONST;
        base     = 0;
        t        = 0;
        drv_cur  = '0;
        drv_prev = '0;
        setCfg(512, 1'b0, 1'b0, 0, 0);
        driveSample(10'd0, 1'b0);

        tbl[0]  = '{10'd508, 1'b1, 1'b0, 10'd508};
        tbl[1]  = '{10'd515, 1'b1, 1'b0, 10'd515};
        tbl[2]  = '{10'd504, 1'b1, 1'b0, 10'd504};
        tbl[3]  = '{10'd512, 1'b1, 1'b0, 10'd512};
        tbl[4]  = '{10'd513, 1'b0, 1'b0, 10'd512};
        tbl[5]  = '{10'd509, 1'b1, 1'b0, 10'd509};
        tbl[6]  = '{10'd500, 1'b1, 1'b0, 10'd500};
        tbl[7]  = '{10'd505, 1'b1, 1'b0, 10'd505};
        tbl[8]  = '{10'd511, 1'b1, 1'b0, 10'd511};
        tbl[9]  = '{10'd512, 1'b0, 1'b0, 10'd511};
        tbl[10] = '{10'd512, 1'b1, 1'b1, 10'd512};
        tbl[11] = '{10'd513, 1'b1, 1'b1, 10'd513};
        tbl[12] = '{10'd514, 1'b0, 1'b0, 10'd513};
        tbl[13] = '{10'd520, 1'b1, 1'b1, 10'd520};

        #3 n_reset = 1'b0;
        tick();
        tick();
        checkOutput("rst_smpl_en", smpl_en, 0);
        checkOutput("rst_smpl_data", smpl_data, 0);
        checkOutput("rst_triggered", triggered, 0);
        checkOutput("rst_forced", forced, 0);
        checkOutput("rst_busy", busy, 0);
        n_reset = 1'b1;
        idleCheck(10);

        $display("[TB] rising trigger on a ramp");
        setCfg(512, 1'b0, 1'b0, 0, 0);
        mode = M_CONST; base = 400;
        armPulse();
        mode = M_RAMP; base = 400; t = 0;
        runCapture(1000, 1, 1, -1, -1, cap_n, cap_fc, cap_v0, cap_vp, cap_f0);
        checkOutput("t1_count", cap_n, 320);
        checkOutput("t1_first", cap_v0, 512);
        checkOutput("t1_before", cap_vp, 511);
        checkOutput("t1_forced", cap_f0, 0);
        idleCheck(20);

        $display("[TB] hysteresis table");
        mode = M_CONST; base = 510;
        armPulse();
        tbl_en = 0;
        for (int i = 0; i < 14; i++) begin
            driveSample(tbl[i].adc, tbl[i].valid);
            tick();
            checkOutput($sformatf("tbl%0d_en", i), smpl_en, tbl[i].exp_en);
            checkOutput($sformatf("tbl%0d_data", i), smpl_data, tbl[i].exp_data);
            if (smpl_en) tbl_en++;
        end
        mode = M_CONST; base = 600;
        runCapture(1000, -1, 1, -1, -1, cap_n, cap_fc, cap_v0, cap_vp, cap_f0);
        checkOutput("t2_count", tbl_en + cap_n, 320);
        idleCheck(10);

        $display("[TB] falling trigger on a triangle");
        setCfg(300, 1'b1, 1'b0, 0, 0);
        mode = M_CONST; base = 200;
        armPulse();
        mode = M_TRI; t = 200;
        runCapture(1000, -1, 1, -1, -1, cap_n, cap_fc, cap_v0, cap_vp, cap_f0);
        checkOutput("t3_count", cap_n, 320);
        checkOutput("t3_first", cap_v0, 300);
        checkOutput("t3_before", cap_vp, 304);
        checkOutput("t3_forced", cap_f0, 0);
        idleCheck(10);

        $display("[TB] decimation by 4");
        setCfg(100, 1'b0, 1'b0, 3, 0);
        mode = M_CONST; base = 0;
        armPulse();
        mode = M_RAMP; base = 0; t = 0;
        runCapture(2000, 4, 4, -1, -1, cap_n, cap_fc, cap_v0, cap_vp, cap_f0);
        checkOutput("t4_count", cap_n, 320);
        checkOutput("t4_first", cap_v0, 103);
        idleCheck(10);

        $display("[TB] auto trigger");
        setCfg(512, 1'b0, 1'b1, 0, 100);
        mode = M_CONST; base = 0;
        armPulse();
        runCapture(1000, 0, 1, -1, -1, cap_n, cap_fc, cap_v0, cap_vp, cap_f0);
        checkOutput("t5_count", cap_n, 320);
        checkOutput("t5_first_cycle", cap_fc, 99);
        checkOutput("t5_forced", cap_f0, 1);
        checkOutput("t5_forced_hold", forced, 1);
        setCfg(512, 1'b0, 1'b0, 0, 100);
        armPulse();
        seekHold(150);
        setCfg(512, 1'b0, 1'b1, 0, 0);
        seekHold(150);
        base = 600;
        runCapture(1000, 0, 1, -1, -1, cap_n, cap_fc, cap_v0, cap_vp, cap_f0);
        checkOutput("t5b_count", cap_n, 320);
        checkOutput("t5b_first", cap_v0, 600);
        checkOutput("t5b_forced", cap_f0, 0);

        $display("[TB] reset mid-capture and arm during capture");
        setCfg(1000, 1'b0, 1'b1, 0, 10);
        mode = M_CONST; base = 0;
        armPulse();
        mode = M_RAMP; base = 0; t = 0;
        runCapture(1000, 1, 1, -1, 50, cap_n, cap_fc, cap_v0, cap_vp, cap_f0);
        checkOutput("t6_pre_count", cap_n, 50);
        checkOutput("t6_pre_forced", forced, 1);
        checkOutput("t6_pre_busy", busy, 1);
        #2 n_reset = 1'b0;
        #1;
        checkOutput("t6_rst_en", smpl_en, 0);
        checkOutput("t6_rst_data", smpl_data, 0);
        checkOutput("t6_rst_trig", triggered, 0);
        checkOutput("t6_rst_forced", forced, 0);
        checkOutput("t6_rst_busy", busy, 0);
        tick();
        tick();
        n_reset = 1'b1;
        idleCheck(30);
        mode = M_CONST; base = 0;
        armPulse();
        mode = M_RAMP; base = 0; t = 0;
        runCapture(1000, 1, 1, 100, -1, cap_n, cap_fc, cap_v0, cap_vp, cap_f0);
        checkOutput("t6_count", cap_n, 320);
        checkOutput("t6_first_cycle", cap_fc, 9);
        checkOutput("t6_first", cap_v0, 9);
        checkOutput("t6_forced", cap_f0, 1);
        idleCheck(60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
